// File: rtl/arm_mc_pkg.sv
// Shared types and constants for the multi-cycle execute unit.
//   op_e    : 3-bit opcode encoding presented on i_Op
//   state_e : control FSM states
//   FLAG_*  : bit positions of {N,Z,C,V} within o_Flags
package arm_mc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_ORR = 3'd3,
    OP_EOR = 3'd4,
    OP_LSL = 3'd5,
    OP_LSR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/arm_mc_iter_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   i_CLK, i_NRESET : clock, async active-low reset
//   start           : load operands (ignored while busy)
//   multiplicand    : operand A
//   multiplier      : operand B
//   busy            : high for exactly BusWidth cycles after a start
//   done            : high during the final iteration cycle
//   product         : low BusWidth bits of the product, valid while done=1
module arm_mc_iter_multiplier #(
  parameter int unsigned BusWidth = 32
) (
  input  logic                i_CLK,
  input  logic                i_NRESET,
  input  logic                start,
  input  logic [BusWidth-1:0] multiplicand,
  input  logic [BusWidth-1:0] multiplier,
  output logic                busy,
  output logic                done,
  output logic [BusWidth-1:0] product
);

  localparam int unsigned CntW = $clog2(BusWidth);
  localparam logic [CntW-1:0] LastCnt = CntW'(BusWidth - 1);

  logic [CntW-1:0]     cnt_q;
  logic [BusWidth-1:0] mcand_q;
  logic [BusWidth-1:0] mplier_q;
  logic [BusWidth-1:0] acc_q;
  logic [BusWidth-1:0] acc_next;

  // Partial product after this cycle's iteration. Exposed directly as the
  // product so the owner can register the final value on the same edge the
  // last iteration retires, keeping result and completion aligned.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product  = acc_next;
  assign done     = busy && (cnt_q == LastCnt);

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      busy     <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (!busy) begin
      if (start) begin
        busy     <= 1'b1;
        cnt_q    <= '0;
        mcand_q  <= multiplicand;
        mplier_q <= multiplier;
        acc_q    <= '0;
      end
    end else begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == LastCnt) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/arm_mc_exec_unit.sv
// Multi-cycle execute unit: single-cycle ALU/shift ops plus an iterative MUL.
// Ports:
//   i_CLK, i_NRESET      : clock, async active-low reset
//   i_Start              : request, sampled only when idle
//   i_Op                 : opcode (ADD SUB AND ORR EOR LSL LSR MUL)
//   i_Set_Flags          : update o_Flags at completion when set
//   i_Src_A, i_Src_B     : operands (B[log2(BusWidth)-1:0] is the shift amount)
//   o_Busy               : high while a MUL iterates
//   o_Done               : one-cycle completion pulse
//   o_Result, o_Flags    : registered result and {N,Z,C,V}
module arm_mc_exec_unit
  import arm_mc_pkg::*;
#(
  parameter int unsigned BusWidth = 32
) (
  input  logic                i_CLK,
  input  logic                i_NRESET,
  input  logic                i_Start,
  input  logic [2:0]          i_Op,
  input  logic                i_Set_Flags,
  input  logic [BusWidth-1:0] i_Src_A,
  input  logic [BusWidth-1:0] i_Src_B,
  output logic                o_Busy,
  output logic                o_Done,
  output logic [BusWidth-1:0] o_Result,
  output logic [3:0]          o_Flags
);

  localparam int unsigned ShW = $clog2(BusWidth);
  localparam int unsigned Msb = BusWidth - 1;

  state_e              state_q, state_d;
  op_e                 op;
  logic                accept;
  logic                mul_start;
  logic                mul_busy;
  logic                mul_done;
  logic [BusWidth-1:0] mul_product;
  logic                mul_set_flags_q;

  logic [ShW-1:0]      amt;
  logic [BusWidth:0]   sum, diff, shl, shr;
  logic [BusWidth-1:0] alu_res;
  logic [3:0]          alu_flags;

  assign op        = op_e'(i_Op);
  assign accept    = i_Start && (state_q == S_IDLE);
  assign mul_start = accept && (op == OP_MUL);
  assign o_Busy    = mul_busy;

  arm_mc_iter_multiplier #(
    .BusWidth(BusWidth)
  ) u_mul (
    .i_CLK       (i_CLK),
    .i_NRESET    (i_NRESET),
    .start       (mul_start),
    .multiplicand(i_Src_A),
    .multiplier  (i_Src_B),
    .busy        (mul_busy),
    .done        (mul_done),
    .product     (mul_product)
  );

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mul_start) state_d = S_MUL;
      S_MUL:   if (mul_done)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Extended-width arithmetic: bit BusWidth of sum/diff is carry/borrow;
  // for shl it is the last bit shifted out, for shr that bit lands in bit 0.
  assign amt  = i_Src_B[ShW-1:0];
  assign sum  = {1'b0, i_Src_A} + {1'b0, i_Src_B};
  assign diff = {1'b0, i_Src_A} - {1'b0, i_Src_B};
  assign shl  = {1'b0, i_Src_A} << amt;
  assign shr  = {i_Src_A, 1'b0} >> amt;

  always_comb begin
    alu_res   = '0;
    alu_flags = o_Flags;
    case (op)
      OP_ADD: begin
        alu_res = sum[BusWidth-1:0];
        alu_flags[FLAG_C] = sum[BusWidth];
        alu_flags[FLAG_V] = (i_Src_A[Msb] == i_Src_B[Msb]) && (alu_res[Msb] != i_Src_A[Msb]);
      end
      OP_SUB: begin
        alu_res = diff[BusWidth-1:0];
        alu_flags[FLAG_C] = ~diff[BusWidth];
        alu_flags[FLAG_V] = (i_Src_A[Msb] != i_Src_B[Msb]) && (alu_res[Msb] != i_Src_A[Msb]);
      end
      OP_AND: alu_res = i_Src_A & i_Src_B;
      OP_ORR: alu_res = i_Src_A | i_Src_B;
      OP_EOR: alu_res = i_Src_A ^ i_Src_B;
      OP_LSL: begin
        alu_res = shl[BusWidth-1:0];
        if (amt != '0) alu_flags[FLAG_C] = shl[BusWidth];
      end
      OP_LSR: begin
        alu_res = shr[BusWidth:1];
        if (amt != '0) alu_flags[FLAG_C] = shr[0];
      end
      default: alu_res = '0;
    endcase
    alu_flags[FLAG_N] = alu_res[Msb];
    alu_flags[FLAG_Z] = (alu_res == '0);
  end

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      o_Done          <= 1'b0;
      o_Result        <= '0;
      o_Flags         <= 4'b0000;
      mul_set_flags_q <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      if (accept && (op != OP_MUL)) begin
        o_Result <= alu_res;
        o_Done   <= 1'b1;
        if (i_Set_Flags) o_Flags <= alu_flags;
      end else if (mul_done) begin
        o_Result <= mul_product;
        o_Done   <= 1'b1;
        if (mul_set_flags_q) begin
          o_Flags[FLAG_N] <= mul_product[Msb];
          o_Flags[FLAG_Z] <= (mul_product == '0);
        end
      end
      if (mul_start) mul_set_flags_q <= i_Set_Flags;
    end
  end

endmodule
